nlc_ch_scheduler: RTL and testbench

//  Time-shares one NLC correction core across NCH ADC channels. Round-robin arbitrates channel

---
 rtl/nlc_pkg.sv | 28 ++
 rtl/nlc_rr_arbiter.sv | 39 +++
 rtl/nlc_ch_scheduler.sv | 166 ++++++++++++++++
 tb/tb_nlc_ch_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nlc_pkg.sv
// nlc_pkg -- shared definitions for the NLC channel scheduler.
//   nlc_state_e : scheduler FSM encoding (IDLE..DONE)
//   SEL_*       : parameter-bank word selects (cfg_sel_i / nlc_param_o word index)
//   NLC_*_DEF   : default sample / parameter word widths
package nlc_pkg;

    localparam int NLC_XW_DEF = 21;
    localparam int NLC_CW_DEF = 32;
    localparam int NLC_NSEL   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } nlc_state_e;

    localparam logic [2:0] SEL_C0    = 3'd0;
    localparam logic [2:0] SEL_C1    = 3'd1;
    localparam logic [2:0] SEL_C2    = 3'd2;
    localparam logic [2:0] SEL_C3    = 3'd3;
    localparam logic [2:0] SEL_C4    = 3'd4;
    localparam logic [2:0] SEL_C5    = 3'd5;
    localparam logic [2:0] SEL_RSTD  = 3'd6;
    localparam logic [2:0] SEL_NMEAN = 3'd7;

endpackage

// File: rtl/nlc_rr_arbiter.sv
// nlc_rr_arbiter -- combinational round-robin pick.
//   i_req    : per-channel request vector
//   i_ptr    : last-served channel; search starts at i_ptr+1 and wraps
//   o_gnt_oh : one-hot of the selected channel (0 when nothing requests)
//   o_idx    : index of the selected channel
//   o_vld    : at least one request present
module nlc_rr_arbiter
    import nlc_pkg::*;
#(
    parameter  int NCH = 16,
    localparam int CHW = $clog2(NCH)
)(
    input  logic [NCH-1:0] i_req,
    input  logic [CHW-1:0] i_ptr,
    output logic [NCH-1:0] o_gnt_oh,
    output logic [CHW-1:0] o_idx,
    output logic           o_vld
);

    logic [CHW-1:0] w_cand;

    always_comb begin
        o_gnt_oh = '0;
        o_idx    = '0;
        o_vld    = 1'b0;
        w_cand   = '0;
        // Offsets 1..NCH; offset NCH wraps onto i_ptr itself, so the channel
        // served last is only picked when nobody else is asking.
        for (int i = 1; i <= NCH; i++) begin
            w_cand = i_ptr + CHW'(i);
            if (!o_vld && i_req[w_cand]) begin
                o_vld = 1'b1;
                o_idx = w_cand;
            end
        end
        if (o_vld) o_gnt_oh[o_idx] = 1'b1;
    end

endmodule

// File: rtl/nlc_ch_scheduler.sv
// nlc_ch_scheduler -- time-shares one NLC correction core across NCH ADC channels.
// One sample in flight: IDLE -> LOAD (grant) -> ISSUE (start core) -> WAIT -> DONE (result).
// Optional watchdog on WAIT: define NLC_SCHED_TIMEOUT_EN.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   req_i/x_adc_i     : per-channel request and packed samples (ch k at [k*XW +: XW])
//   gnt_o             : one-cycle one-hot grant (sample captured)
//   cfg_*             : parameter-bank write port (ch, word select, data)
//   nlc_srdyi_o       : one-cycle core start; nlc_x_adc_o / nlc_param_o held until next capture
//   nlc_srdyo_i/x_lin : core result handshake
//   res_*             : one-cycle result strobe with channel tag and corrected sample
//   busy_o            : not IDLE
//   tmo_err_o         : sticky watchdog flag
module nlc_ch_scheduler
    import nlc_pkg::*;
#(
    parameter  int NCH     = 16,
    parameter  int XW      = NLC_XW_DEF,
    parameter  int CW      = NLC_CW_DEF,
    parameter  int TMO_CYC = 255,
    localparam int CHW     = $clog2(NCH)
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         req_i,
    input  logic [NCH*XW-1:0]      x_adc_i,
    output logic [NCH-1:0]         gnt_o,
    input  logic                   cfg_we_i,
    input  logic [CHW-1:0]         cfg_ch_i,
    input  logic [2:0]             cfg_sel_i,
    input  logic [CW-1:0]          cfg_data_i,
    output logic                   nlc_srdyi_o,
    output logic [XW-1:0]          nlc_x_adc_o,
    output logic [NLC_NSEL*CW-1:0] nlc_param_o,
    input  logic                   nlc_srdyo_i,
    input  logic [XW-1:0]          nlc_x_lin_i,
    output logic                   res_valid_o,
    output logic [CHW-1:0]         res_ch_o,
    output logic [XW-1:0]          res_x_lin_o,
    output logic                   busy_o,
    output logic                   tmo_err_o
);

    nlc_state_e r_state, w_state_nxt;

    logic [NCH-1:0][NLC_NSEL-1:0][CW-1:0] r_bank;
    logic [NLC_NSEL-1:0][CW-1:0]          r_param;
    logic [NCH-1:0][XW-1:0]               w_x_arr;
    logic [XW-1:0]                        r_x;
    logic [XW-1:0]                        r_res_x;
    logic [CHW-1:0]                       r_ch;
    logic [CHW-1:0]                       r_ptr;
    logic [NCH-1:0]                       r_gnt_oh;
    logic [NCH-1:0]                       w_pick_oh;
    logic [CHW-1:0]                       w_pick_idx;
    logic                                 w_pick_vld;
    logic                                 w_capture;
    logic                                 w_tmo_hit;

    assign w_x_arr = x_adc_i;

    nlc_rr_arbiter #(.NCH(NCH)) u_arb (
        .i_req    (req_i),
        .i_ptr    (r_ptr),
        .o_gnt_oh (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_vld    (w_pick_vld)
    );

    assign w_capture = (r_state == ST_IDLE) && w_pick_vld;

`ifdef NLC_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo_err;

    // Counter holds the number of WAIT cycles already elapsed; the limit is
    // hit on the TMO_CYC-th WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (r_state == ST_WAIT) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            else                    r_tmo_cnt <= '0;
            if (w_tmo_hit)          r_tmo_err <= 1'b1;
        end
    end

    assign tmo_err_o = r_tmo_err;
`else
    // No watchdog: the limit has no meaning here, the compare is always false.
    assign tmo_err_o = (TMO_CYC < 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmo_hit   = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_pick_vld) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A result arriving on the expiry cycle takes priority.
                if (nlc_srdyo_i) w_state_nxt = ST_DONE;
`ifdef NLC_SCHED_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
`endif
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture reads the bank before this edge's cfg write lands, so a write
    // to the word being captured is seen only on the channel's next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bank <= '0;
        end else if (cfg_we_i) begin
            r_bank[cfg_ch_i][cfg_sel_i] <= cfg_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ch     <= '0;
            r_x      <= '0;
            r_param  <= '0;
            r_gnt_oh <= '0;
            r_res_x  <= '0;
            r_ptr    <= CHW'(NCH - 1);
        end else begin
            if (w_capture) begin
                r_ch     <= w_pick_idx;
                r_x      <= w_x_arr[w_pick_idx];
                r_param  <= r_bank[w_pick_idx];
                r_gnt_oh <= w_pick_oh;
            end
            if (r_state == ST_WAIT) begin
                if (nlc_srdyo_i)    r_res_x <= nlc_x_lin_i;
                else if (w_tmo_hit) r_res_x <= '0;
            end
            if (r_state == ST_DONE) r_ptr <= r_ch;
        end
    end

    assign gnt_o       = (r_state == ST_LOAD) ? r_gnt_oh : '0;
    assign nlc_srdyi_o = (r_state == ST_ISSUE);
    assign nlc_x_adc_o = r_x;
    assign nlc_param_o = r_param;
    assign res_valid_o = (r_state == ST_DONE);
    assign res_ch_o    = r_ch;
    assign res_x_lin_o = r_res_x;
    assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_nlc_ch_scheduler.sv
// Scoreboard bench for nlc_ch_scheduler: stimulus pushes expected grants,
// core issues and results; a negedge monitor pops and compares them.
module tb_nlc_ch_scheduler;

    localparam int NCH = 16;
    localparam int XW  = 21;
    localparam int CW  = 32;
    localparam int CHW = 4;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH-1:0]    req = '0;
    logic [NCH*XW-1:0] xv = '0;
    logic              cfg_we = 1'b0;
    logic [CHW-1:0]    cfg_ch = '0;
    logic [2:0]        cfg_sel = '0;
    logic [CW-1:0]     cfg_data = '0;
    logic              core_srdyo = 1'b0;
    logic [XW-1:0]     core_xlin = '0;
    logic              stray_srdyo = 1'b0;
    logic              srdyo;
    logic [XW-1:0]     xlin;

    logic [NCH-1:0]    gnt_o;
    logic              nlc_srdyi_o;
    logic [XW-1:0]     nlc_x_adc_o;
    logic [8*CW-1:0]   nlc_param_o;
    logic              res_valid_o;
    logic [CHW-1:0]    res_ch_o;
    logic [XW-1:0]     res_x_lin_o;
    logic              busy_o;
    logic              tmo_err_o;

    assign srdyo = core_srdyo | stray_srdyo;
    assign xlin  = stray_srdyo ? 21'h1FFFF : core_xlin;

    always #5 clk = ~clk;

    nlc_ch_scheduler #(.NCH(NCH), .XW(XW), .CW(CW), .TMO_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .req_i(req), .x_adc_i(xv), .gnt_o(gnt_o),
        .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_sel_i(cfg_sel), .cfg_data_i(cfg_data),
        .nlc_srdyi_o(nlc_srdyi_o), .nlc_x_adc_o(nlc_x_adc_o), .nlc_param_o(nlc_param_o),
        .nlc_srdyo_i(srdyo), .nlc_x_lin_i(xlin), .res_valid_o(res_valid_o),
        .res_ch_o(res_ch_o), .res_x_lin_o(res_x_lin_o), .busy_o(busy_o), .tmo_err_o(tmo_err_o)
    );

    int nvec = 0;
    int nerr = 0;

    logic [7:0][CW-1:0]     mbank [NCH];
    int                     q_gnt [$];
    logic [XW+8*CW-1:0]     q_iss [$];
    logic [CHW+XW-1:0]      q_res [$];

    bit core_silent = 1'b0;
    int core_lat    = 2;
    bit sticky      = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [XW-1:0] xof(input int k);
        return xv[k*XW +: XW];
    endfunction

    // Core stand-in: fixed answer for the directed sample, otherwise an XOR mask.
    function automatic logic [XW-1:0] core_fn(input logic [XW-1:0] x);
        return (x == 21'h0ABCD) ? 21'h01234 : (x ^ 21'h15A5A);
    endfunction

    function automatic logic [NCH-1:0] onehot(input int k);
        logic [NCH-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic push_exp(input int ch, input bit has_res, input logic [XW-1:0] rx);
        q_gnt.push_back(ch);
        q_iss.push_back({xof(ch), mbank[ch]});
        if (has_res) q_res.push_back({CHW'(ch), rx});
    endtask

    task automatic tick();
        @(negedge clk);
        if (gnt_o != '0 && !sticky) req = req & ~gnt_o;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((req != '0 || busy_o) && n < 400);
        if (req != '0 || busy_o) chk("wait_idle_timeout", {req != '0, busy_o}, 0);
    endtask

    task automatic wait_srdyi();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!nlc_srdyi_o && n < 50);
        if (!nlc_srdyi_o) chk("wait_srdyi_timeout", nlc_srdyi_o, 1);
    endtask

    task automatic cfg_write(input int ch, input int sel, input logic [CW-1:0] d);
        cfg_we   = 1'b1;
        cfg_ch   = CHW'(ch);
        cfg_sel  = 3'(sel);
        cfg_data = d;
        mbank[ch][sel] = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Core model
    logic [XW-1:0] core_x;
    initial begin
        forever begin
            @(negedge clk);
            if (nlc_srdyi_o && !core_silent && !reset) begin
                core_x = core_fn(nlc_x_adc_o);
                repeat (core_lat) @(negedge clk);
                core_srdyo = 1'b1;
                core_xlin  = core_x;
                @(negedge clk);
                core_srdyo = 1'b0;
            end
        end
    end

    // Monitor
    bit                 prev_gnt = 1'b0;
    int                 m_ch;
    logic [XW+8*CW-1:0] m_iss;
    logic [CHW+XW-1:0]  m_res;
    always @(negedge clk) begin
        if (!reset) begin
            if (gnt_o != '0) begin
                if (q_gnt.size() == 0) chk("gnt_unexpected", gnt_o, 0);
                else begin
                    m_ch = q_gnt.pop_front();
                    chk("gnt", gnt_o, onehot(m_ch));
                end
            end
            if (nlc_srdyi_o) begin
                chk("srdyi_after_gnt", prev_gnt, 1);
                if (q_iss.size() == 0) chk("srdyi_unexpected", 1, 0);
                else begin
                    m_iss = q_iss.pop_front();
                    chk("issue_x", nlc_x_adc_o, m_iss[8*CW +: XW]);
                    chk("issue_param", nlc_param_o, m_iss[8*CW-1:0]);
                end
            end
            if (res_valid_o) begin
                if (q_res.size() == 0) chk("res_unexpected", {res_ch_o, res_x_lin_o}, 0);
                else begin
                    m_res = q_res.pop_front();
                    chk("res_ch", res_ch_o, m_res[XW +: CHW]);
                    chk("res_x_lin", res_x_lin_o, m_res[XW-1:0]);
                end
            end
            prev_gnt = (gnt_o != '0);
        end else begin
            prev_gnt = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int g, n;
        for (int k = 0; k < NCH; k++) begin
            xv[k*XW +: XW] = XW'(32'h10000 + k * 273);
            mbank[k] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_srdyi", nlc_srdyi_o, 0);
        chk("rst_x_adc", nlc_x_adc_o, 0);
        chk("rst_param", nlc_param_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_res_ch", res_ch_o, 0);
        chk("rst_res_x", res_x_lin_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_tmo", tmo_err_o, 0);
        reset = 1'b0;

        // 1: reset asserted while waiting on the core
        core_silent = 1'b1;
        push_exp(7, 1'b0, '0);
        req = 16'h0080;
        wait_srdyi();
        repeat (3) tick();
        chk("t1_busy_in_wait", busy_o, 1);
        #1 reset = 1'b1;
        #1;
        chk("t1_gnt", gnt_o, 0);
        chk("t1_srdyi", nlc_srdyi_o, 0);
        chk("t1_x_adc", nlc_x_adc_o, 0);
        chk("t1_res_valid", res_valid_o, 0);
        chk("t1_res_ch", res_ch_o, 0);
        chk("t1_res_x", res_x_lin_o, 0);
        chk("t1_busy", busy_o, 0);
        @(negedge clk);
        reset = 1'b0;
        core_silent = 1'b0;
        // Pointer back at 15: ch0 before ch7
        core_lat = 2;
        push_exp(0, 1'b1, core_fn(xof(0)));
        push_exp(7, 1'b1, core_fn(xof(7)));
        req = 16'h0081;
        wait_idle();

        // 2: single channel with configured params, latency check
        cfg_write(3, 0, 32'h11111111);
        cfg_write(3, 7, 32'hFFFF0000);
        xv[3*XW +: XW] = 21'h0ABCD;
        push_exp(3, 1'b1, 21'h01234);
        req = 16'h0008;
        tick();
        chk("t2_gnt_lat", gnt_o, 16'h0008);
        tick();
        chk("t2_srdyi_lat", nlc_srdyi_o, 1);
        wait_idle();

        // 3: all channels held, pointer at 3 -> 4..15,0..4
        core_lat = 3;
        for (int i = 0; i < 17; i++) push_exp((4 + i) % NCH, 1'b1, core_fn(xof((4 + i) % NCH)));
        sticky = 1'b1;
        req = '1;
        g = 0;
        n = 0;
        while (g < 17 && n < 400) begin
            tick();
            n++;
            if (gnt_o != '0) g++;
        end
        req = '0;
        sticky = 1'b0;
        if (g < 17) chk("t3_grant_count", g, 17);
        wait_idle();

        // 4: ch5 re-requests right after its grant, ch9 still wins next
        core_lat = 1;
        push_exp(5, 1'b1, core_fn(xof(5)));
        push_exp(9, 1'b1, core_fn(xof(9)));
        push_exp(5, 1'b1, core_fn(xof(5)));
        req = 16'h0220;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt_o == '0 && n < 20);
        if (gnt_o == '0) chk("t4_first_gnt_timeout", gnt_o, 16'h0020);
        tick();
        req[5] = 1'b1;
        wait_idle();

        // 5: cfg write to the channel in flight
        cfg_write(2, 1, 32'hA5A50001);
        core_lat = 8;
        push_exp(2, 1'b1, core_fn(xof(2)));
        req = 16'h0004;
        wait_srdyi();
        tick();
        cfg_write(2, 1, 32'hB0B00002);
        tick();
        chk("t5_param_inflight", nlc_param_o[CW +: CW], 32'hA5A50001);
        wait_idle();
        chk("t5_param_hold", nlc_param_o[CW +: CW], 32'hA5A50001);
        core_lat = 2;
        push_exp(2, 1'b1, core_fn(xof(2)));
        req = 16'h0004;
        wait_idle();
        // Write and capture on the same edge: capture sees the old word
        push_exp(2, 1'b1, core_fn(xof(2)));
        req = 16'h0004;
        cfg_write(2, 1, 32'hC3C30003);
        wait_idle();

        // Stray core result while idle is ignored
        stray_srdyo = 1'b1;
        tick();
        stray_srdyo = 1'b0;
        tick();
        chk("stray_res_valid", res_valid_o, 0);
        chk("stray_busy", busy_o, 0);
        tick();
        chk("stray_res_valid2", res_valid_o, 0);
        chk("stray_res_x_hold", res_x_lin_o, core_fn(xof(2)));

`ifdef NLC_SCHED_TIMEOUT_EN
        // 6: silent core -> watchdog after TMO WAIT cycles
        core_silent = 1'b1;
        push_exp(6, 1'b1, '0);
        req = 16'h0040;
        wait_srdyi();
        for (int i = 0; i < TMO; i++) begin
            tick();
            chk("t6_tmo_early", tmo_err_o, 0);
        end
        tick();
        chk("t6_tmo_set", tmo_err_o, 1);
        chk("t6_res_valid", res_valid_o, 1);
        wait_idle();
        chk("t6_tmo_sticky", tmo_err_o, 1);
        core_silent = 1'b0;
`else
        chk("tmo_tied_low", tmo_err_o, 0);
`endif

        repeat (3) tick();
        chk("q_gnt_empty", q_gnt.size(), 0);
        chk("q_iss_empty", q_iss.size(), 0);
        chk("q_res_empty", q_res.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
